// File: rtl/leg_intc_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and the layout of the IRQID/FIQID words.
package leg_intc_pkg;

    // Word offsets of the software-visible registers.
    localparam logic [2:0] INTC_PENDING = 3'd0;
    localparam logic [2:0] INTC_ENABLE  = 3'd1;
    localparam logic [2:0] INTC_FIQSEL  = 3'd2;
    localparam logic [2:0] INTC_IRQID   = 3'd3;
    localparam logic [2:0] INTC_FIQID   = 3'd4;
    localparam logic [2:0] INTC_EOI     = 3'd5;

    // Field positions inside an ID register word.
    localparam int INTC_ID_VALID_BIT = 31;
    localparam int INTC_ID_MSB       = 4;
    localparam int INTC_ID_LSB       = 0;
    localparam int INTC_ID_WIDTH     = INTC_ID_MSB - INTC_ID_LSB + 1;

    // Per-class request/service state.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } intc_state_t;

    // Pack a valid flag and source ID into the 32-bit ID register layout.
    function automatic logic [31:0] intcIdWord(input logic valid,
                                               input logic [INTC_ID_WIDTH-1:0] id);
        logic [31:0] word;
        word = '0;
        word[INTC_ID_VALID_BIT] = valid;
        word[INTC_ID_MSB:INTC_ID_LSB] = id;
        return word;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest one.
module intc_prio_enc
    import leg_intc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]             i_req,
    output logic                     o_any,
    output logic [INTC_ID_WIDTH-1:0] o_id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_id  = '0;
        o_any = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = INTC_ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches source rising edges into sticky pending bits,
// masks and routes them to IRQ or FIQ, and runs an independent
// request/acknowledge/EOI handshake for each class.
module interrupt_controller
    import leg_intc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] IntSrc,
    input  logic            IRQAssert,
    input  logic            FIQAssert,
    input  logic [2:0]      RegAddr,
    input  logic            RegWE,
    input  logic [31:0]     RegWD,
    output logic [31:0]     RegRD,
    output logic            IRQ,
    output logic            FIQ
);

    logic [NSRC-1:0]          r_srcPrev;
    logic [NSRC-1:0]          r_pending;
    logic [NSRC-1:0]          r_enable;
    logic [NSRC-1:0]          r_fiqSel;
    intc_state_t              r_irqState;
    intc_state_t              r_fiqState;
    logic                     r_irqValid;
    logic                     r_fiqValid;
    logic [INTC_ID_WIDTH-1:0] r_irqId;
    logic [INTC_ID_WIDTH-1:0] r_fiqId;
    logic                     r_irq;
    logic                     r_fiq;
    logic [31:0]              r_regRd;

    logic [NSRC-1:0]          w_edge;
    logic [NSRC-1:0]          w_irqCand;
    logic [NSRC-1:0]          w_fiqCand;
    logic                     w_irqAny;
    logic                     w_fiqAny;
    logic [INTC_ID_WIDTH-1:0] w_irqWinId;
    logic [INTC_ID_WIDTH-1:0] w_fiqWinId;
    logic                     w_irqTake;
    logic                     w_fiqTake;
    logic [NSRC-1:0]          w_irqClr;
    logic [NSRC-1:0]          w_fiqClr;
    logic [NSRC-1:0]          w_w1c;
    logic                     w_irqEoi;
    logic                     w_fiqEoi;
    logic                     w_unusedWd;

    assign w_edge    = IntSrc & ~r_srcPrev;
    assign w_irqCand = r_pending & r_enable & ~r_fiqSel;
    assign w_fiqCand = r_pending & r_enable & r_fiqSel;

    intc_prio_enc #(.N(NSRC)) u_irqEnc (
        .i_req (w_irqCand),
        .o_any (w_irqAny),
        .o_id  (w_irqWinId)
    );

    intc_prio_enc #(.N(NSRC)) u_fiqEnc (
        .i_req (w_fiqCand),
        .o_any (w_fiqAny),
        .o_id  (w_fiqWinId)
    );

    // An acknowledge only counts while a class is requesting a live candidate.
    assign w_irqTake = (r_irqState == REQ) && w_irqAny && IRQAssert;
    assign w_fiqTake = (r_fiqState == REQ) && w_fiqAny && FIQAssert;
    assign w_irqClr  = w_irqTake ? (NSRC'(1) << w_irqWinId) : '0;
    assign w_fiqClr  = w_fiqTake ? (NSRC'(1) << w_fiqWinId) : '0;

    assign w_w1c    = (RegWE && RegAddr == INTC_PENDING) ? RegWD[NSRC-1:0] : '0;
    assign w_irqEoi = RegWE && (RegAddr == INTC_EOI) && RegWD[0];
    assign w_fiqEoi = RegWE && (RegAddr == INTC_EOI) && RegWD[1];

    assign w_unusedWd = ^RegWD;

    assign RegRD = r_regRd;
    assign IRQ   = r_irq;
    assign FIQ   = r_fiq;

    // Edge detection, sticky pending bits (a new edge beats any clear) and
    // the software-writable mask and routing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_srcPrev <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_fiqSel  <= '0;
        end else begin
            r_srcPrev <= IntSrc;
            r_pending <= (r_pending & ~w_w1c & ~w_irqClr & ~w_fiqClr) | w_edge;
            if (RegWE) begin
                case (RegAddr)
                    INTC_ENABLE: r_enable <= RegWD[NSRC-1:0];
                    INTC_FIQSEL: r_fiqSel <= RegWD[NSRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    // IRQ class handshake: request, capture on ack, then wait for EOI.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqState <= IDLE;
            r_irq      <= 1'b0;
            r_irqValid <= 1'b0;
            r_irqId    <= '0;
        end else begin
            case (r_irqState)
                IDLE: begin
                    r_irq <= w_irqAny;
                    if (w_irqAny) r_irqState <= REQ;
                end
                REQ: begin
                    if (!w_irqAny) begin
                        r_irqState <= IDLE;
                        r_irq      <= 1'b0;
                    end else if (IRQAssert) begin
                        r_irqState <= SERVICE;
                        r_irq      <= 1'b0;
                        r_irqValid <= 1'b1;
                        r_irqId    <= w_irqWinId;
                    end else begin
                        r_irq <= 1'b1;
                    end
                end
                SERVICE: begin
                    r_irq <= 1'b0;
                    if (w_irqEoi) begin
                        r_irqState <= IDLE;
                        r_irqValid <= 1'b0;
                    end
                end
                default: begin
                    r_irqState <= IDLE;
                    r_irq      <= 1'b0;
                end
            endcase
        end
    end

    // FIQ class handshake, identical to the IRQ one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fiqState <= IDLE;
            r_fiq      <= 1'b0;
            r_fiqValid <= 1'b0;
            r_fiqId    <= '0;
        end else begin
            case (r_fiqState)
                IDLE: begin
                    r_fiq <= w_fiqAny;
                    if (w_fiqAny) r_fiqState <= REQ;
                end
                REQ: begin
                    if (!w_fiqAny) begin
                        r_fiqState <= IDLE;
                        r_fiq      <= 1'b0;
                    end else if (FIQAssert) begin
                        r_fiqState <= SERVICE;
                        r_fiq      <= 1'b0;
                        r_fiqValid <= 1'b1;
                        r_fiqId    <= w_fiqWinId;
                    end else begin
                        r_fiq <= 1'b1;
                    end
                end
                SERVICE: begin
                    r_fiq <= 1'b0;
                    if (w_fiqEoi) begin
                        r_fiqState <= IDLE;
                        r_fiqValid <= 1'b0;
                    end
                end
                default: begin
                    r_fiqState <= IDLE;
                    r_fiq      <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; EOI and reserved offsets read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regRd <= '0;
        end else begin
            case (RegAddr)
                INTC_PENDING: r_regRd <= 32'(r_pending);
                INTC_ENABLE:  r_regRd <= 32'(r_enable);
                INTC_FIQSEL:  r_regRd <= 32'(r_fiqSel);
                INTC_IRQID:   r_regRd <= intcIdWord(r_irqValid, r_irqId);
                INTC_FIQID:   r_regRd <= intcIdWord(r_fiqValid, r_fiqId);
                default:      r_regRd <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a per-cycle vector table for
// the basic IRQ flows plus hand-written multi-cycle sequences.
module tb_interrupt_controller;
    import leg_intc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  IntSrc;
    logic        IRQAssert;
    logic        FIQAssert;
    logic [2:0]  RegAddr;
    logic        RegWE;
    logic [31:0] RegWD;
    logic [31:0] RegRD;
    logic        IRQ;
    logic        FIQ;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  src;
        logic        irqAck;
        logic        fiqAck;
        logic        expIrq;
        logic        expFiq;
        logic        chkRd;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [20];

    interrupt_controller #(.NSRC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .IntSrc    (IntSrc),
        .IRQAssert (IRQAssert),
        .FIQAssert (FIQAssert),
        .RegAddr   (RegAddr),
        .RegWE     (RegWE),
        .RegWD     (RegWD),
        .RegRD     (RegRD),
        .IRQ       (IRQ),
        .FIQ       (FIQ)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [2:0] addr,
                                input logic [31:0] wd, input logic [7:0] src,
                                input logic ia, input logic fa,
                                input logic eI, input logic eF,
                                input logic cR, input logic [31:0] eR);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.src = src;
        v.irqAck = ia; v.fiqAck = fa;
        v.expIrq = eI; v.expFiq = eF; v.chkRd = cR; v.expRd = eR;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and let one clock edge sample them.
    task automatic applyStimulus(input logic we, input logic [2:0] addr,
                                 input logic [31:0] wd, input logic [7:0] src,
                                 input logic irqAck, input logic fiqAck);
        RegWE     = we;
        RegAddr   = addr;
        RegWD     = wd;
        IntSrc    = src;
        IRQAssert = irqAck;
        FIQAssert = fiqAck;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Read a register while holding the current source levels.
    task automatic regRead(input logic [2:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, addr, 32'h0, IntSrc, 1'b0, 1'b0);
        data = RegRD;
    endtask

    logic [31:0] rd;

    initial begin
        // Single IRQ on source 0, then two simultaneous sources with priority.
        vecs[0]  = mk(1, INTC_ENABLE,  32'h01, 8'h00, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, INTC_PENDING, 32'h0,  8'h01, 0, 0, 0, 0, 1, 32'h0);
        vecs[2]  = mk(0, INTC_PENDING, 32'h0,  8'h00, 0, 0, 1, 0, 1, 32'h01);
        vecs[3]  = mk(0, INTC_IRQID,   32'h0,  8'h00, 1, 0, 0, 0, 1, 32'h0);
        vecs[4]  = mk(0, INTC_IRQID,   32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h8000_0000);
        vecs[5]  = mk(0, INTC_PENDING, 32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h0);
        vecs[6]  = mk(1, INTC_EOI,     32'h1,  8'h00, 0, 0, 0, 0, 1, 32'h0);
        vecs[7]  = mk(0, INTC_IRQID,   32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h0);
        vecs[8]  = mk(1, INTC_ENABLE,  32'h0C, 8'h00, 0, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mk(0, INTC_PENDING, 32'h0,  8'h0C, 0, 0, 0, 0, 1, 32'h0);
        vecs[10] = mk(0, INTC_PENDING, 32'h0,  8'h0C, 0, 0, 1, 0, 1, 32'h0C);
        vecs[11] = mk(0, INTC_PENDING, 32'h0,  8'h00, 1, 0, 0, 0, 1, 32'h0C);
        vecs[12] = mk(0, INTC_IRQID,   32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h8000_0002);
        vecs[13] = mk(0, INTC_PENDING, 32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h08);
        vecs[14] = mk(1, INTC_EOI,     32'h1,  8'h00, 0, 0, 0, 0, 0, 32'h0);
        vecs[15] = mk(0, INTC_PENDING, 32'h0,  8'h00, 0, 0, 1, 0, 1, 32'h08);
        vecs[16] = mk(0, INTC_PENDING, 32'h0,  8'h00, 1, 0, 0, 0, 1, 32'h08);
        vecs[17] = mk(0, INTC_IRQID,   32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h8000_0003);
        vecs[18] = mk(1, INTC_EOI,     32'h1,  8'h00, 0, 0, 0, 0, 0, 32'h0);
        vecs[19] = mk(0, INTC_PENDING, 32'h0,  8'h00, 0, 0, 0, 0, 1, 32'h0);

        reset = 1'b1;
        applyStimulus(0, INTC_PENDING, 32'h0, 8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0, 8'h00, 0, 0);
        checkOutput("reset IRQ",   {31'b0, IRQ}, 32'h0);
        checkOutput("reset FIQ",   {31'b0, FIQ}, 32'h0);
        checkOutput("reset RegRD", RegRD,        32'h0);
        reset = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].src,
                          vecs[i].irqAck, vecs[i].fiqAck);
            checkOutput($sformatf("vec%0d IRQ", i), {31'b0, IRQ}, {31'b0, vecs[i].expIrq});
            checkOutput($sformatf("vec%0d FIQ", i), {31'b0, FIQ}, {31'b0, vecs[i].expFiq});
            if (vecs[i].chkRd) begin
                checkOutput($sformatf("vec%0d RegRD", i), RegRD, vecs[i].expRd);
            end
        end

        $display("[TB] IRQ and FIQ together");
        applyStimulus(1, INTC_FIQSEL,  32'h10, 8'h00, 0, 0);
        applyStimulus(1, INTC_ENABLE,  32'h11, 8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h11, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("both IRQ", {31'b0, IRQ}, 32'h1);
        checkOutput("both FIQ", {31'b0, FIQ}, 32'h1);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 1);
        checkOutput("fiq ack FIQ", {31'b0, FIQ}, 32'h0);
        checkOutput("fiq ack IRQ", {31'b0, IRQ}, 32'h1);
        regRead(INTC_FIQID, rd);
        checkOutput("FIQID", rd, 32'h8000_0004);
        checkOutput("IRQ held", {31'b0, IRQ}, 32'h1);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 1, 0);
        checkOutput("both service IRQ", {31'b0, IRQ}, 32'h0);
        checkOutput("both service FIQ", {31'b0, FIQ}, 32'h0);
        regRead(INTC_IRQID, rd);
        checkOutput("IRQID src0", rd, 32'h8000_0000);
        applyStimulus(1, INTC_EOI,     32'h3,  8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("after EOI IRQ", {31'b0, IRQ}, 32'h0);
        checkOutput("after EOI FIQ", {31'b0, FIQ}, 32'h0);

        $display("[TB] withdraw a request before ack");
        applyStimulus(1, INTC_FIQSEL,  32'h0,  8'h00, 0, 0);
        applyStimulus(1, INTC_ENABLE,  32'h01, 8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h01, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("w1c pre IRQ", {31'b0, IRQ}, 32'h1);
        applyStimulus(1, INTC_PENDING, 32'h01, 8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("w1c drop IRQ", {31'b0, IRQ}, 32'h0);
        regRead(INTC_PENDING, rd);
        checkOutput("w1c PENDING", rd, 32'h0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h01, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("mask pre IRQ", {31'b0, IRQ}, 32'h1);
        applyStimulus(1, INTC_ENABLE,  32'h0,  8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("mask drop IRQ", {31'b0, IRQ}, 32'h0);
        applyStimulus(1, INTC_PENDING, 32'h01, 8'h00, 0, 0);

        $display("[TB] edge coincident with ack capture");
        applyStimulus(1, INTC_ENABLE,  32'h02, 8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h02, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        checkOutput("src1 IRQ", {31'b0, IRQ}, 32'h1);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h02, 1, 0);
        checkOutput("src1 ack IRQ", {31'b0, IRQ}, 32'h0);
        regRead(INTC_PENDING, rd);
        checkOutput("set wins PENDING", rd, 32'h02);
        regRead(INTC_IRQID, rd);
        checkOutput("IRQID src1", rd, 32'h8000_0001);
        applyStimulus(1, INTC_EOI,     32'h1,  8'h02, 0, 0);
        checkOutput("EOI edge IRQ", {31'b0, IRQ}, 32'h0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h02, 0, 0);
        checkOutput("re-request IRQ", {31'b0, IRQ}, 32'h1);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h02, 1, 0);

        $display("[TB] reset during service");
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'hFF, 0, 0);
        regRead(INTC_PENDING, rd);
        checkOutput("pre-reset PENDING", rd, 32'hFF);
        checkOutput("pre-reset IRQ", {31'b0, IRQ}, 32'h0);
        reset = 1'b1;
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 0, 0);
        reset = 1'b0;
        checkOutput("mid reset IRQ",   {31'b0, IRQ}, 32'h0);
        checkOutput("mid reset FIQ",   {31'b0, FIQ}, 32'h0);
        checkOutput("mid reset RegRD", RegRD,        32'h0);
        for (int a = 0; a < 5; a++) begin
            regRead(3'(a), rd);
            checkOutput($sformatf("post-reset reg%0d", a), rd, 32'h0);
        end
        applyStimulus(1, INTC_EOI,     32'h3,  8'h00, 1, 1);
        applyStimulus(0, INTC_PENDING, 32'h0,  8'h00, 1, 1);
        checkOutput("post-reset ack IRQ", {31'b0, IRQ}, 32'h0);
        checkOutput("post-reset ack FIQ", {31'b0, FIQ}, 32'h0);
        regRead(INTC_IRQID, rd);
        checkOutput("post-reset IRQID", rd, 32'h0);
        regRead(INTC_FIQID, rd);
        checkOutput("post-reset FIQID", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
